// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared types and constants for the FFT size planner
//
// Purpose: planner FSM state encoding, radix constants and the default
//          per-radix stage limits shared with the FFT stage scheduler.
// Ports:   none (package).
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FACTOR = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int RADIX2 = 2;
  localparam int RADIX3 = 3;
  localparam int RADIX5 = 5;

  localparam int DEF_MAX_S2 = 8;
  localparam int DEF_MAX_S3 = 5;
  localparam int DEF_MAX_S5 = 2;

endpackage

// File: rtl/fft_radix_step.sv
// rtl/fft_radix_step.sv - combinational divisibility test of a residue by 2, 3 and 5
//
// Purpose: one factorisation step's arithmetic; divisors are fixed constants,
//          so each quotient reduces to constant-divisor logic.
// Ports:
//   r_i            residue under test
//   div2_o/3_o/5_o residue is an exact multiple of 2 / 3 / 5
//   q2_o/q3_o/q5_o residue divided by 2 / 3 / 5 (floor)
module fft_radix_step
  import fft_pkg::*;
#(
  parameter int N_W = 12
) (
  input  logic [N_W-1:0] r_i,
  output logic           div2_o,
  output logic           div3_o,
  output logic           div5_o,
  output logic [N_W-1:0] q2_o,
  output logic [N_W-1:0] q3_o,
  output logic [N_W-1:0] q5_o
);

  assign q2_o = r_i / N_W'(RADIX2);
  assign q3_o = r_i / N_W'(RADIX3);
  assign q5_o = r_i / N_W'(RADIX5);

  // Exact divisibility: multiplying the floor quotient back must give r.
  // q*k <= r always, so the shift-add never overflows N_W bits.
  assign div2_o = (q2_o << 1) == r_i;
  assign div3_o = ((q3_o << 1) + q3_o) == r_i;
  assign div5_o = ((q5_o << 2) + q5_o) == r_i;

endmodule

// File: rtl/fft_size_planner.sv
// rtl/fft_size_planner.sv - sequential radix-2/3/5 factoriser for mixed-radix FFT sizes
//
// Purpose: accepts a DFT size N, strips factors of 2, 3, 5 one per clock and
//          reports stage counts and powers, or err if N is not plannable.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready/n_in  size request handshake
//   out_valid/out_ready     result handshake
//   err                     N not plannable (qualified by out_valid)
//   stage2/3/5              per-radix stage counts
//   pow2/3/5, pow3x5        per-radix powers and 3x5 product
module fft_size_planner
  import fft_pkg::*;
#(
  parameter  int N_W    = 12,
  parameter  int MAX_S2 = DEF_MAX_S2,
  parameter  int MAX_S3 = DEF_MAX_S3,
  parameter  int MAX_S5 = DEF_MAX_S5,
  localparam int S2_W   = $clog2(MAX_S2 + 1),
  localparam int S3_W   = $clog2(MAX_S3 + 1),
  localparam int S5_W   = $clog2(MAX_S5 + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [N_W-1:0]  n_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            err,
  output logic [S2_W-1:0] stage2,
  output logic [S3_W-1:0] stage3,
  output logic [S5_W-1:0] stage5,
  output logic [N_W-1:0]  pow2,
  output logic [N_W-1:0]  pow3,
  output logic [N_W-1:0]  pow5,
  output logic [N_W-1:0]  pow3x5
);

  state_e          state_q, state_d;
  logic [N_W-1:0]  r_q, r_d;
  logic [S2_W-1:0] s2_q, s2_d;
  logic [S3_W-1:0] s3_q, s3_d;
  logic [S5_W-1:0] s5_q, s5_d;
  logic [N_W-1:0]  p2_q, p2_d;
  logic [N_W-1:0]  p3_q, p3_d;
  logic [N_W-1:0]  p5_q, p5_d;
  logic [N_W-1:0]  p35_q, p35_d;
  logic            err_q, err_d;

  logic            div2, div3, div5;
  logic [N_W-1:0]  q2, q3, q5;
  logic            consumed;
  logic            ok;

  fft_radix_step #(.N_W(N_W)) u_step (
    .r_i    (r_q),
    .div2_o (div2),
    .div3_o (div3),
    .div5_o (div5),
    .q2_o   (q2),
    .q3_o   (q3),
    .q5_o   (q5)
  );

  assign consumed = (s2_q != '0) || (s3_q != '0) || (s5_q != '0);

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    s2_d    = s2_q;
    s3_d    = s3_q;
    s5_d    = s5_q;
    p2_d    = p2_q;
    p3_d    = p3_q;
    p5_d    = p5_q;
    p35_d   = p35_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          r_d     = n_in;
          s2_d    = '0;
          s3_d    = '0;
          s5_d    = '0;
          p2_d    = N_W'(1);
          p3_d    = N_W'(1);
          p5_d    = N_W'(1);
          p35_d   = N_W'(1);
          err_d   = 1'b0;
          state_d = FACTOR;
        end
      end

      FACTOR: begin
        if (r_q == N_W'(1) && consumed) begin
          state_d = DONE;
        end else if (r_q < N_W'(2)) begin
          // N of 0 or 1 has no radix decomposition.
          err_d   = 1'b1;
          state_d = DONE;
        end else if (div2) begin
          if (s2_q == S2_W'(MAX_S2)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d  = q2;
            s2_d = s2_q + S2_W'(1);
            p2_d = p2_q << 1;
          end
        end else if (div3) begin
          if (s3_q == S3_W'(MAX_S3)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d   = q3;
            s3_d  = s3_q + S3_W'(1);
            p3_d  = (p3_q << 1) + p3_q;
            p35_d = (p35_q << 1) + p35_q;
          end
        end else if (div5) begin
          if (s5_q == S5_W'(MAX_S5)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            r_d   = q5;
            s5_d  = s5_q + S5_W'(1);
            p5_d  = (p5_q << 2) + p5_q;
            p35_d = (p35_q << 2) + p35_q;
          end
        end else begin
          // Residue has a prime factor other than 2, 3, 5.
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      s2_q    <= '0;
      s3_q    <= '0;
      s5_q    <= '0;
      p2_q    <= '0;
      p3_q    <= '0;
      p5_q    <= '0;
      p35_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      s5_q    <= s5_d;
      p2_q    <= p2_d;
      p3_q    <= p3_d;
      p5_q    <= p5_d;
      p35_q   <= p35_d;
      err_q   <= err_d;
    end
  end

  // Results are exposed only in DONE and only for a successful plan, so a
  // partial factorisation or an error never leaks non-zero values.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign err       = out_valid & err_q;
  assign ok        = out_valid & ~err_q;

  assign stage2 = ok ? s2_q  : '0;
  assign stage3 = ok ? s3_q  : '0;
  assign stage5 = ok ? s5_q  : '0;
  assign pow2   = ok ? p2_q  : '0;
  assign pow3   = ok ? p3_q  : '0;
  assign pow5   = ok ? p5_q  : '0;
  assign pow3x5 = ok ? p35_q : '0;

endmodule

// File: tb/tb_fft_size_planner.sv
// tb/tb_fft_size_planner.sv - directed self-checking bench for fft_size_planner
module tb_fft_size_planner;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] n_in;
  logic        out_valid;
  logic        out_ready;
  logic        err;
  logic [3:0]  stage2;
  logic [2:0]  stage3;
  logic [1:0]  stage5;
  logic [11:0] pow2;
  logic [11:0] pow3;
  logic [11:0] pow5;
  logic [11:0] pow3x5;

  int n_checks = 0;
  int n_pass   = 0;

  fft_size_planner dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_in      (n_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .err       (err),
    .stage2    (stage2),
    .stage3    (stage3),
    .stage5    (stage5),
    .pow2      (pow2),
    .pow3      (pow3),
    .pow5      (pow5),
    .pow3x5    (pow3x5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic check_outputs(input string tag, input logic e,
                               input int s2, input int s3, input int s5,
                               input int p2, input int p3, input int p5, input int p35);
    check({tag, ".err"},    32'(err),    32'(e));
    check({tag, ".stage2"}, 32'(stage2), 32'(s2));
    check({tag, ".stage3"}, 32'(stage3), 32'(s3));
    check({tag, ".stage5"}, 32'(stage5), 32'(s5));
    check({tag, ".pow2"},   32'(pow2),   32'(p2));
    check({tag, ".pow3"},   32'(pow3),   32'(p3));
    check({tag, ".pow5"},   32'(pow5),   32'(p5));
    check({tag, ".pow3x5"}, 32'(pow3x5), 32'(p35));
  endtask

  // Called #1 after an edge; returns #1 after the acceptance edge.
  task automatic accept(input string tag, input int n);
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    n_in     = 12'(n);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Counts edges after acceptance until out_valid rises (bounded).
  task automatic wait_result(input string tag, input int lat);
    int edges;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      edges = i;
      if (out_valid) break;
    end
    if (!out_valid) edges = 99;
    check({tag, ".latency"}, 32'(edges), 32'(lat));
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, ".hs_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ".hs_in_ready"},  32'(in_ready),  32'd1);
  endtask

  task automatic run_case(input string tag, input int n, input int lat, input logic e,
                          input int s2, input int s3, input int s5,
                          input int p2, input int p3, input int p5, input int p35);
    accept(tag, n);
    wait_result(tag, lat);
    check_outputs(tag, e, s2, s3, s5, p2, p3, p5, p35);
    handshake(tag);
  endtask

  initial begin
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    n_in      = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    check("rst.in_ready",  32'(in_ready),  32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check_outputs("rst", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    //        tag       N     lat err s2 s3 s5 p2   p3   p5  p35
    run_case("n12",    12,    4, 0, 2, 1, 0,   4,   3,  1,   3);
    run_case("n1200",  1200,  8, 0, 4, 1, 2,  16,   3, 25,  75);
    run_case("n14",    14,    2, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n0",     0,     1, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n1",     1,     1, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n7",     7,     1, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n512",   512,   9, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n3125",  3125,  3, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n256",   256,   9, 0, 8, 0, 0, 256,   1,  1,   1);
    run_case("n243",   243,   6, 0, 0, 5, 0,   1, 243,  1, 243);
    run_case("n729",   729,   6, 1, 0, 0, 0,   0,   0,  0,   0);
    run_case("n2",     2,     2, 0, 1, 0, 0,   2,   1,  1,   1);

    // Backpressure: result held while out_ready low; a new request waits.
    accept("bp60", 60);
    wait_result("bp60", 5);
    in_valid = 1'b1;
    n_in     = 12'd36;
    for (int i = 0; i < 5; i++) begin
      check("bp60.hold_valid", 32'(out_valid), 32'd1);
      check("bp60.hold_in_ready", 32'(in_ready), 32'd0);
      check_outputs("bp60.hold", 1'b0, 2, 1, 1, 4, 3, 5, 15);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp.after_hs_out_valid", 32'(out_valid), 32'd0);
    check("bp.after_hs_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp36.accepted", 32'(in_ready), 32'd0);
    wait_result("bp36", 5);
    check_outputs("bp36", 1'b0, 2, 2, 0, 4, 9, 1, 9);
    handshake("bp36");

    // Reset in the middle of factoring N=1200.
    accept("mrst", 1200);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mrst.in_ready",  32'(in_ready),  32'd1);
    check("mrst.out_valid", 32'(out_valid), 32'd0);
    check_outputs("mrst", 1'b0, 0, 0, 0, 0, 0, 0, 0);
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) stale++;
    end
    check("mrst.no_stale", 32'(stale), 32'd0);
    run_case("post_rst12", 12, 4, 0, 2, 1, 0, 4, 3, 1, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
